// File: rtl/wave_pkg.sv
// Shared types and default widths for the waveform capture/display path.
// Also used by wave_display_top so both sides agree on RAM geometry.
package wave_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int ADDR_W       = 8;
    localparam int OUT_W        = 8;
    localparam int TRIG_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Top bits of a two's complement sample, recoded as offset binary
    function automatic logic [OUT_W-1:0] to_offset(
        input logic [SAMPLE_W-1:0] s
    );
        logic [OUT_W-1:0] r;
        r = s[SAMPLE_W-1 -: OUT_W];
        r[OUT_W-1] = ~r[OUT_W-1];
        return r;
    endfunction

endpackage

// File: rtl/wave_trigger_capture_if.sv
// Sample stream in, waveform RAM write port and display control out.
// master drives the stream side, slave is the capture block.
interface wave_trigger_capture_if
    import wave_pkg::*;
#(
    parameter int SW = SAMPLE_W,
    parameter int AW = ADDR_W,
    parameter int OW = OUT_W
) ();

    logic          new_sample;
    logic [SW-1:0] sample;
    logic          vsync;
    logic          freeze;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [OW-1:0] wr_data;
    logic          read_half;
    logic          capture_done;
    logic [1:0]    state;

    modport master (
        output new_sample, sample, vsync, freeze,
        input  wr_en, wr_addr, wr_data, read_half, capture_done, state
    );

    modport slave (
        input  new_sample, sample, vsync, freeze,
        output wr_en, wr_addr, wr_data, read_half, capture_done, state
    );

endinterface

// File: rtl/edge_detect_rise.sv
// Registered rising-edge pulse: one cycle high, one cycle after d_i rises.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic rise_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d_i;
            rise_q <= d_i & ~d_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/wave_trigger_capture.sv
// Zero-crossing triggered frame capture into a double-buffered waveform RAM.
// The displayed half only swaps on vsync, so a frame is never torn.
module wave_trigger_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W_P     = SAMPLE_W,
    parameter int ADDR_W_P       = ADDR_W,
    parameter int OUT_W_P        = OUT_W,
    parameter int TRIG_TIMEOUT_P = TRIG_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    wave_trigger_capture_if.slave bus
);

    localparam int CNT_W = $clog2(TRIG_TIMEOUT_P);

    state_e                state_q;
    logic [ADDR_W_P-1:0]   idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  prev_neg_q;
    logic                  read_half_q;
    logic                  wr_en_q;
    logic [ADDR_W_P:0]     wr_addr_q;
    logic [OUT_W_P-1:0]    wr_data_q;
    logic                  done_q;
    logic                  vs_rise;
    logic                  msb;
    logic                  trig_d;
    logic                  tmo_d;
    logic [OUT_W_P-1:0]    data_d;

    edge_detect_rise u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (bus.vsync),
        .rise_o (vs_rise)
    );

    assign msb    = bus.sample[SAMPLE_W_P-1];
    assign trig_d = bus.new_sample & prev_neg_q & ~msb;
    assign tmo_d  = bus.new_sample &
                    (cnt_q == CNT_W'(TRIG_TIMEOUT_P - 1));
    assign data_d = to_offset(bus.sample);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ARMED;
            idx_q       <= '0;
            cnt_q       <= '0;
            prev_neg_q  <= 1'b0;
            read_half_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.new_sample)
                prev_neg_q <= msb;
            case (state_q)
                ST_ARMED: begin
                    if (trig_d || tmo_d) begin
                        state_q   <= ST_ACTIVE;
                        idx_q     <= ADDR_W_P'(1);
                        cnt_q     <= '0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {~read_half_q, ADDR_W_P'(0)};
                        wr_data_q <= data_d;
                    end else if (bus.new_sample) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.new_sample) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {~read_half_q, idx_q};
                        wr_data_q <= data_d;
                        idx_q     <= idx_q + 1'b1;
                        if (&idx_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (vs_rise && !bus.freeze) begin
                        read_half_q <= ~read_half_q;
                        state_q     <= ST_ARMED;
                    end
                end
                default: state_q <= ST_ARMED;
            endcase
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.read_half    = read_half_q;
    assign bus.capture_done = done_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_wave_trigger_capture.sv
// Directed bench for wave_trigger_capture: trigger, timeout, swap, freeze, reset.
module tb_wave_trigger_capture;
    import wave_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wave_trigger_capture_if bus ();

    wave_trigger_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nwr   = 0;
    int ndone = 0;
    int base;
    logic [8:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic       last_done = 1'b0;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            nwr       <= nwr + 1;
            last_addr <= bus.wr_addr;
            last_data <= bus.wr_data;
            last_done <= bus.capture_done;
        end
        if (bus.capture_done)
            ndone <= ndone + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] v, input int gap);
        @(negedge clk);
        bus.new_sample = 1'b1;
        bus.sample     = v;
        @(negedge clk);
        bus.new_sample = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        bus.vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"}, 32'(bus.state), 32'd0);
        check({pfx, "_rh"}, 32'(bus.read_half), 32'd0);
        check({pfx, "_wren"}, 32'(bus.wr_en), 32'd0);
        check({pfx, "_waddr"}, 32'(bus.wr_addr), 32'd0);
        check({pfx, "_wdata"}, 32'(bus.wr_data), 32'd0);
        check({pfx, "_done"}, 32'(bus.capture_done), 32'd0);
    endtask

    initial begin
        bus.new_sample = 1'b0;
        bus.sample     = '0;
        bus.vsync      = 1'b0;
        bus.freeze     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // ramp through zero: trigger on the 0 sample
        for (int v = -4; v < 0; v++) send(16'(v), 20);
        check("no_early_wr", 32'(nwr), 32'd0);
        send(16'h0000, 20);
        check("trig_addr", 32'(last_addr), 32'h100);
        check("trig_data", 32'(last_data), 32'h80);
        check("trig_state", 32'(bus.state), 32'd1);
        check("trig_nwr", 32'(nwr), 32'd1);
        for (int v = 1; v <= 4; v++) send(16'(v), 20);
        check("ramp4_addr", 32'(last_addr), 32'h104);
        for (int i = 5; i < 256; i++) send(16'(i << 8), 4);
        check("f1_last_addr", 32'(last_addr), 32'h1FF);
        check("f1_last_data", 32'(last_data), 32'h7F);
        check("f1_done_align", 32'(last_done), 32'd1);
        check("f1_state", 32'(bus.state), 32'd2);
        check("f1_nwr", 32'(nwr), 32'd256);
        check("f1_ndone", 32'(ndone), 32'd1);

        // sample in WAIT is dropped; then vsync swap
        send(16'h0100, 4);
        check("wait_no_wr", 32'(nwr), 32'd256);
        check("wait_state", 32'(bus.state), 32'd2);
        @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        check("swap_1cyc", 32'(bus.read_half), 32'd0);
        @(negedge clk);
        check("swap_2cyc", 32'(bus.read_half), 32'd1);
        check("swap_state", 32'(bus.state), 32'd0);
        bus.vsync = 1'b0;

        // DC input: forced capture on the 1024th strobe
        base = nwr;
        repeat (1023) send(16'h0100, 4);
        check("tmo_no_wr", 32'(nwr), 32'(base));
        check("tmo_armed", 32'(bus.state), 32'd0);
        send(16'h0100, 4);
        check("tmo_nwr", 32'(nwr), 32'(base + 1));
        check("tmo_addr", 32'(last_addr), 32'h000);
        check("tmo_data", 32'(last_data), 32'h81);
        check("tmo_state", 32'(bus.state), 32'd1);
        repeat (255) send(16'h0100, 4);
        check("f2_last_addr", 32'(last_addr), 32'h0FF);
        check("f2_state", 32'(bus.state), 32'd2);
        check("f2_ndone", 32'(ndone), 32'd2);

        // freeze holds the displayed half across vsyncs
        bus.freeze = 1'b1;
        vs_pulse();
        vs_pulse();
        check("frz_rh", 32'(bus.read_half), 32'd1);
        check("frz_state", 32'(bus.state), 32'd2);
        bus.freeze = 1'b0;
        repeat (3) @(negedge clk);
        check("unfrz_no_edge", 32'(bus.read_half), 32'd1);
        vs_pulse();
        check("unfrz_rh", 32'(bus.read_half), 32'd0);
        check("unfrz_state", 32'(bus.state), 32'd0);

        // reset in the middle of a capture
        send(16'hFFFF, 4);
        send(16'h0000, 4);
        check("f3_first", 32'(last_addr), 32'h100);
        repeat (99) send(16'h0200, 4);
        check("f3_idx100", 32'(last_addr), 32'h163);
        check("f3_state", 32'(bus.state), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        @(negedge clk);
        reset = 1'b0;
        base = nwr;
        send(16'hFFFF, 4);
        check("post_no_wr", 32'(nwr), 32'(base));
        send(16'h0000, 4);
        check("post_nwr", 32'(nwr), 32'(base + 1));
        check("post_addr", 32'(last_addr), 32'h100);
        check("post_data", 32'(last_data), 32'h80);
        check("post_state", 32'(bus.state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
